// File: rtl/edge_pkg.sv
// Shared types and pixel widths for the edge-detection pipeline front end.
package edge_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} gray_state_t;
    localparam int RGB_W  = 24;
    localparam int GRAY_W = 8;
endpackage

// File: rtl/grayscale_if.sv
// FIFO-side signals of the grayscale stage: RGB input FIFO, gray output FIFO and frame done.
interface grayscale_if;
    import edge_pkg::*;

    logic              in_rd_en;
    logic              in_empty;
    logic [RGB_W-1:0]  in_dout;
    logic              gray_wr_en;
    logic              gray_full;
    logic [GRAY_W-1:0] gray_din;
    logic              done;

    modport master (
        output in_rd_en, gray_wr_en, gray_din, done,
        input  in_empty, in_dout, gray_full
    );

    modport slave (
        input  in_rd_en, gray_wr_en, gray_din, done,
        output in_empty, in_dout, gray_full
    );
endinterface

// File: rtl/gray_pipe.sv
// Two-stage luminance datapath: S1 registers R+G+B, S2 registers the truncated sum/3.
module gray_pipe
    import edge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              load,
    input  logic [RGB_W-1:0]  rgb,
    output logic              vld_p2,
    output logic [GRAY_W-1:0] gray_p2
);
    localparam int SUM_W = 10;

    logic             vld_p1;
    logic [SUM_W-1:0] sum_p1;

    function automatic logic [SUM_W-1:0] rgb_sum(input logic [RGB_W-1:0] px);
        return SUM_W'(px[23:16]) + SUM_W'(px[15:8]) + SUM_W'(px[7:0]);
    endfunction

    // Max sum is 765, so the quotient always fits in GRAY_W bits.
    function automatic logic [GRAY_W-1:0] div3(input logic [SUM_W-1:0] s);
        return GRAY_W'(s / SUM_W'(3));
    endfunction

    // S1: sum stage
    always_ff @(posedge clk) begin
        if (!stall && load) begin
            sum_p1 <= rgb_sum(rgb);
        end
    end

    // S2: divide stage; data only updates on a valid S1 so gray_p2 holds across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            gray_p2 <= '0;
        end else if (!stall) begin
            vld_p1 <= load;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                gray_p2 <= div3(sum_p1);
            end
        end
    end
endmodule

// File: rtl/grayscale.sv
// RGB-to-luminance front end: pops RGB pixels, writes gray pixels, pulses done per frame.
module grayscale
    import edge_pkg::*;
#(
    parameter int IMG_HEIGHT = 720,
    parameter int IMG_WIDTH  = 540
)
(
    input  logic clock,
    input  logic reset,
    grayscale_if.master bus
);
    localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    gray_state_t       state, state_nxt;
    logic [CNT_W-1:0]  rd_count, wr_count;
    logic              armed;
    logic              stall, pop, write;
    logic              vld_p2;
    logic [GRAY_W-1:0] gray_p2;

    // armed keeps the stage from popping in the first cycle after reset
    assign stall = vld_p2 & bus.gray_full;
    assign pop   = ~bus.in_empty & ~stall & (state == RUN) & armed & ~reset;
    assign write = vld_p2 & ~bus.gray_full & ~reset;

    assign bus.in_rd_en   = pop;
    assign bus.gray_wr_en = write;
    assign bus.gray_din   = gray_p2;
    assign bus.done       = (state == DONE);

    gray_pipe u_pipe (
        .clk     (clock),
        .rst     (reset),
        .stall   (stall),
        .load    (pop),
        .rgb     (bus.in_dout),
        .vld_p2  (vld_p2),
        .gray_p2 (gray_p2)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (pop && rd_count == LAST_PIX) state_nxt = DRAIN;
            DRAIN:   if (write && wr_count == LAST_PIX) state_nxt = DONE;
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            rd_count <= '0;
            wr_count <= '0;
            armed    <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (state == DONE) begin
                rd_count <= '0;
                wr_count <= '0;
            end else begin
                if (pop)   rd_count <= rd_count + CNT_W'(1);
                if (write) wr_count <= wr_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/grayscale.md
# grayscale

Front-end conversion stage of the edge-detection pipeline. It pops packed 24-bit RGB pixels from the input FIFO and converts each to an 8-bit luminance value, (R+G+B)/3 truncated. It pushes the result into the gray FIFO that feeds the Sobel stage. It counts pixels per frame and pulses `done` once the last pixel of a frame has been written.

## Interface
- `IMG_HEIGHT`, 720, frame height in pixels
- `IMG_WIDTH`, 540, frame width in pixels
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears state, counters and pipeline
- `in_rd_en`  out  1  pop request to RGB FIFO
- `in_empty`  in  1  RGB FIFO empty
- `in_dout`  in  24  RGB pixel: [23:16]=R, [15:8]=G, [7:0]=B; first-word-fall-through, valid while `in_empty`=0
- `gray_wr_en`  out  1  push strobe to gray FIFO
- `gray_full`  in  1  gray FIFO full
- `gray_din`  out  8  luminance pixel
- `done`  out  1  one-cycle pulse after a frame's final write

## Operation
- Constant `FRAME_PIXELS` = IMG_WIDTH*IMG_HEIGHT.
- Datapath is a 2-stage pipeline with one valid bit per stage.
  - S1 registers the 10-bit zero-extended sum R+G+B (max 765).
  - S2 registers `sum/3`, truncated, in 8 bits (max 255, no saturation needed).
- `stall` = s2_valid & gray_full. On stall both stages and all counters hold.
- `gray_wr_en` = s2_valid & ~gray_full. `gray_din` = S2 data. Both are driven from registers; there is no combinational path from `in_dout`.
- `in_rd_en` = ~in_empty & ~stall & (state==RUN).
- A pop loads S1 with valid=1. Otherwise S1 loads valid=0, unless stalled.
- `rd_count` increments on each pop. `wr_count` increments on each write.
- State machine (enum RUN, DRAIN, DONE):
  - RUN: a pop with rd_count==FRAME_PIXELS-1 → DRAIN.
  - DRAIN: no pops. A write with wr_count==FRAME_PIXELS-1 → DONE.
  - DONE: `done`=1 for exactly this cycle. Counters clear → RUN. Pipeline is already empty.
- Reset values: state RUN, counters 0, both valid bits 0, S2 data 0, `done` 0. Consequently `in_rd_en`=0, `gray_wr_en`=0 and `gray_din`=0 during the reset cycle and the first cycle after it.
- A reset asserted mid-frame discards in-flight pixels; no write occurs in the cycle after reset. The upstream FIFO is not flushed by this block.

## Timing
- Latency: pixel popped on edge N appears on `gray_din` with `gray_wr_en`=1 in cycle N+2 if `gray_full`=0.
- Throughput: 1 pixel/clock with no backpressure.
- When `gray_full` rises with S2 valid, `gray_din` holds its value until the write is accepted. No pixel is dropped or duplicated.
- Simultaneous `in_empty`=0 and stall: no pop.
- Bubble case: S2 empty and `gray_full`=1 → not a stall, so S1 may advance into S2.
- `done` rises the clock after the final write. The first pop of the next frame can occur in the cycle after `done`.
- `in_rd_en` is low for the whole of DRAIN and DONE. Pixels of the next frame waiting in the FIFO are not consumed early.

## Structure
- Package `edge_pkg`:
  - `gray_state_t` enum {RUN, DRAIN, DONE}.
  - Pixel width constants `RGB_W`=24 and `GRAY_W`=8.
- Sub-module `gray_pipe`: the two-stage sum/divide datapath with valid bits and stall input, instantiated once.
- FSM, counters and handshake logic live in `grayscale`.

## Test plan
- Single pixel R=30,G=60,B=90, `IMG_WIDTH`=1, `IMG_HEIGHT`=1 → `gray_din`=60 two cycles after the pop; `done` pulses one cycle after the write.
- Extremes 0xFFFFFF → 255, 0x000000 → 0, 0x010000 → 0, 0x020101 → 1 (truncation).
- 4×2 frame streamed continuously → 8 writes on consecutive cycles, order preserved. `in_rd_en` is low after the 8th pop until `done`. `done` is high for exactly 1 cycle.
- `gray_full` held high for 5 cycles mid-frame → S2 value held constant and `gray_wr_en`=0 throughout. No pops occur while stalled. Every value is written exactly once after release.
- `in_empty` toggling every other cycle → output gaps match input gaps. Frame totals stay correct and `done` fires after pixel FRAME_PIXELS.
- `reset` pulsed after 3 of 8 pixels → no write the next cycle, `done` stays 0, counters restart. A fresh 8-pixel frame then completes with a single `done` pulse.
